pipe_skid_reg: RTL

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg.sv | 113 +++++++++++
 1 files changed

// File: rtl/pipe_skid_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_skid_reg : registered valid/ready pipeline stage with a skid buffer |
// | Optional statistics counters enabled by macro PIPE_SKID_REG_STATS_EN.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pipe_skid_reg #(
  parameter int                DATA_W = 96,
  parameter logic [DATA_W-1:0] BUBBLE = {64'h0, 32'h00000013},
  parameter int                CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_SKID_REG_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] skid_reg;
  logic              in_xfer;
  logic              out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // out_data is the main register itself; it is parked at BUBBLE whenever
  // the stage is empty so downstream always sees a NOP when nothing is valid.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state     <= EMPTY;
      out_data  <= BUBBLE;
      skid_reg  <= BUBBLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            state     <= ONE;
            out_data  <= in_data;
            out_valid <= 1'b1;
            in_ready  <= 1'b1;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            out_data <= in_data;
          end else if (in_xfer) begin
            state    <= FULL;
            skid_reg <= in_data;
            in_ready <= 1'b0;
          end else if (out_xfer) begin
            state     <= EMPTY;
            out_data  <= BUBBLE;
            out_valid <= 1'b0;
          end
        end
        FULL: begin
          // in_ready is low here, so the skid register is only ever read.
          if (out_xfer) begin
            state    <= ONE;
            out_data <= skid_reg;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          out_data  <= BUBBLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_SKID_REG_STATS_EN
  localparam logic [CNT_W-1:0] CNT_INC = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // A flush only counts when it actually throws away a held entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt != CNT_MAX) begin
        stall_cnt <= stall_cnt + CNT_INC;
      end
      if (flush && out_valid && flush_cnt != CNT_MAX) begin
        flush_cnt <= flush_cnt + CNT_INC;
      end
    end
  end
`endif

endmodule
`default_nettype wire
